// File: rtl/car_traffic_controller.sv
// car_traffic_controller: owns the eight car positions feeding vga_controller.
// A vsync rising edge starts an 8-cycle walk in which one shared adder moves
// one car per cycle. A level change respawns every car and cancels any walk.
// Optional build macro: CAR_PAUSE_EN (adds the pause input).
module car_traffic_controller #(
  parameter int H_DISPLAY   = 640,
  parameter int LANE_Y0     = 64,
  parameter int LANE_PITCH  = 40,
  parameter int SPAWN_PITCH = 80,
  parameter int MAX_STEP    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic [3:0] current_level,
`ifdef CAR_PAUSE_EN
  input  logic       pause,
`endif
  output logic [9:0] car_x_0,
  output logic [9:0] car_x_1,
  output logic [9:0] car_x_2,
  output logic [9:0] car_x_3,
  output logic [9:0] car_x_4,
  output logic [9:0] car_x_5,
  output logic [9:0] car_x_6,
  output logic [9:0] car_x_7,
  output logic [9:0] car_y_0,
  output logic [9:0] car_y_1,
  output logic [9:0] car_y_2,
  output logic [9:0] car_y_3,
  output logic [9:0] car_y_4,
  output logic [9:0] car_y_5,
  output logic [9:0] car_y_6,
  output logic [9:0] car_y_7,
  output logic       busy
);

  localparam logic [10:0] LP_HD  = 11'(H_DISPLAY);
  localparam logic [4:0]  LP_MAX = 5'(MAX_STEP);

  typedef enum logic {S_IDLE, S_UPDATE} state_t;

  state_t     r_state;
  logic [2:0] r_idx;
  logic       r_vsync_q;
  logic [3:0] r_level_q;
  logic       r_busy;
  logic [9:0] r_x [8];

  logic        w_tick;
  logic        w_start;
  logic        w_lvl_chg;
  logic        w_active;
  logic [9:0]  w_cur_x;
  logic [4:0]  w_step_raw;
  logic [3:0]  w_step;
  logic [10:0] w_sum;
  logic [9:0]  w_right;
  logic [9:0]  w_left;
  logic [9:0]  w_new_x;

  function automatic logic [9:0] spawn_x(input int i);
    return 10'(i * SPAWN_PITCH);
  endfunction

  assign w_tick    = vsync & ~r_vsync_q;
  assign w_lvl_chg = (current_level != r_level_q);
`ifdef CAR_PAUSE_EN
  assign w_start   = w_tick & ~pause;
`else
  assign w_start   = w_tick;
`endif

  // Shared step/wrap adder for the car selected by r_idx.
  always_comb begin
    w_cur_x    = r_x[r_idx];
    w_active   = (current_level > {1'b0, r_idx});
    w_step_raw = 5'd1 + {3'b000, r_idx[1:0]} + {3'b000, current_level[3:2]};
    w_step     = (w_step_raw > LP_MAX) ? LP_MAX[3:0] : w_step_raw[3:0];
    w_sum      = {1'b0, w_cur_x} + {7'b0, w_step};
    w_right    = (w_sum >= LP_HD) ? 10'(w_sum - LP_HD) : w_sum[9:0];
    w_left     = (w_cur_x < {6'b0, w_step})
               ? 10'({1'b0, w_cur_x} + LP_HD - {7'b0, w_step})
               : w_cur_x - {6'b0, w_step};
    w_new_x    = w_cur_x;
    if (w_active) w_new_x = r_idx[0] ? w_left : w_right;
  end

  // Frame FSM: tick detect, level-change respawn, one car per cycle walk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_idx     <= 3'd0;
      r_busy    <= 1'b0;
      r_vsync_q <= 1'b0;
      r_level_q <= current_level;
      for (int i = 0; i < 8; i++) r_x[i] <= spawn_x(i);
    end else begin
      r_vsync_q <= vsync;
      if (w_lvl_chg) begin
        // Respawn wins over both a pending tick and an in-flight walk.
        r_level_q <= current_level;
        r_state   <= S_IDLE;
        r_idx     <= 3'd0;
        r_busy    <= 1'b0;
        for (int i = 0; i < 8; i++) r_x[i] <= spawn_x(i);
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_state <= S_UPDATE;
              r_idx   <= 3'd0;
              r_busy  <= 1'b1;
            end
          end
          S_UPDATE: begin
            r_x[r_idx] <= w_new_x;
            r_idx      <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy    = r_busy;
  assign car_x_0 = r_x[0];
  assign car_x_1 = r_x[1];
  assign car_x_2 = r_x[2];
  assign car_x_3 = r_x[3];
  assign car_x_4 = r_x[4];
  assign car_x_5 = r_x[5];
  assign car_x_6 = r_x[6];
  assign car_x_7 = r_x[7];

  // Lane positions are fixed for the life of the design.
  assign car_y_0 = 10'(LANE_Y0 + 0 * LANE_PITCH);
  assign car_y_1 = 10'(LANE_Y0 + 1 * LANE_PITCH);
  assign car_y_2 = 10'(LANE_Y0 + 2 * LANE_PITCH);
  assign car_y_3 = 10'(LANE_Y0 + 3 * LANE_PITCH);
  assign car_y_4 = 10'(LANE_Y0 + 4 * LANE_PITCH);
  assign car_y_5 = 10'(LANE_Y0 + 5 * LANE_PITCH);
  assign car_y_6 = 10'(LANE_Y0 + 6 * LANE_PITCH);
  assign car_y_7 = 10'(LANE_Y0 + 7 * LANE_PITCH);

endmodule

// File: tb/tb_car_traffic_controller.sv
// Bench for car_traffic_controller: frame-level model checked every cycle,
// plus hand-computed expectations for the documented scenarios.
module tb_car_traffic_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic       pause;
  logic       pause_eff;
  logic [3:0] lvl_in;
  logic [9:0] cx [8];
  logic [9:0] cy [8];
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  car_traffic_controller dut (
    .clk(clk), .reset(reset), .vsync(vsync), .current_level(lvl_in),
`ifdef CAR_PAUSE_EN
    .pause(pause),
`endif
    .car_x_0(cx[0]), .car_x_1(cx[1]), .car_x_2(cx[2]), .car_x_3(cx[3]),
    .car_x_4(cx[4]), .car_x_5(cx[5]), .car_x_6(cx[6]), .car_x_7(cx[7]),
    .car_y_0(cy[0]), .car_y_1(cy[1]), .car_y_2(cy[2]), .car_y_3(cy[3]),
    .car_y_4(cy[4]), .car_y_5(cy[5]), .car_y_6(cy[6]), .car_y_7(cy[7]),
    .busy(busy)
  );

`ifdef CAR_PAUSE_EN
  assign pause_eff = pause;
`else
  assign pause_eff = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- frame-level model ----------------
  int mx [8];
  int tgt [8];
  int m_lvl;
  int m_e;
  bit m_prev;
  bit m_busy;

  function automatic int spawn(input int i);
    return i * 80;
  endfunction

  function automatic int stepf(input int i, input int l);
    int s;
    s = 1 + (i % 4) + (l / 4);
    return (s > 8) ? 8 : s;
  endfunction

  // Position of car i one frame later at level l.
  function automatic int nxt(input int x, input int i, input int l);
    if (l <= i) return x;
    if (i % 2 == 0) return (x + stepf(i, l)) % 640;
    return (x - stepf(i, l) + 640) % 640;
  endfunction

  // At the tick edge the whole next frame is known; car k shows it k+1 edges later.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mx[i] <= spawn(i);
      m_busy <= 1'b0;
      m_prev <= 1'b0;
      m_lvl  <= int'(lvl_in);
      m_e    <= 0;
    end else begin
      m_prev <= vsync;
      if (int'(lvl_in) != m_lvl) begin
        for (int i = 0; i < 8; i++) mx[i] <= spawn(i);
        m_lvl  <= int'(lvl_in);
        m_busy <= 1'b0;
      end else if (m_busy) begin
        mx[m_e] <= tgt[m_e];
        m_e     <= m_e + 1;
        if (m_e == 7) m_busy <= 1'b0;
      end else if (vsync && !m_prev && !pause_eff) begin
        for (int i = 0; i < 8; i++) tgt[i] <= nxt(mx[i], i, m_lvl);
        m_busy <= 1'b1;
        m_e    <= 0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("model car_x_%0d", i), int'(cx[i]), mx[i]);
        chk($sformatf("model car_y_%0d", i), int'(cy[i]), 64 + 40 * i);
      end
      chk("model busy", int'(busy), int'(m_busy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic frame();
    vsync = 1'b1;
    repeat (2) sync();
    vsync = 1'b0;
    repeat (10) sync();
  endtask

  initial begin
    int nb;
    lvl_in = 4'd0;
    vsync  = 1'b0;
    pause  = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset  = 1'b0;
    chk_en = 1'b1;

    // 1: reset values
    @(negedge clk);
    chk("rst car_x_3", int'(cx[3]), 240);
    chk("rst car_y_3", int'(cy[3]), 184);
    chk("rst car_y_7", int'(cy[7]), 344);
    chk("rst busy", int'(busy), 0);
    sync();

    // 2: level 1, single frame
    lvl_in = 4'd1;
    repeat (2) sync();
    vsync = 1'b1;
    nb = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (busy) nb++;
      if (c == 2) vsync = 1'b0;
    end
    chk("busy cycles", nb, 8);
    chk("l1 car_x_0", int'(cx[0]), 1);
    chk("l1 car_x_1 inactive", int'(cx[1]), 80);
    sync();

    // 3: level 8, left-mover wrap on car 1
    lvl_in = 4'd8;
    repeat (2) sync();
    repeat (20) frame();
    @(negedge clk);
    chk("t20 car_x_1", int'(cx[1]), 0);
    sync();
    frame();
    @(negedge clk);
    chk("t21 car_x_1 wrap", int'(cx[1]), 636);
    chk("t21 car_x_0", int'(cx[0]), 63);
    sync();

    // 4: level 15, right-mover wrap on car 6
    lvl_in = 4'd15;
    repeat (2) sync();
    repeat (40) frame();
    @(negedge clk);
    chk("l15 car_x_6", int'(cx[6]), 80);
    sync();

    // 5: level change 8->9 in the third UPDATE cycle
    lvl_in = 4'd8;
    repeat (2) sync();
    vsync = 1'b1;
    repeat (3) sync();
    lvl_in = 4'd9;
    @(negedge clk);
    chk("pre-abort busy", int'(busy), 1);
    chk("pre-abort car_x_0", int'(cx[0]), 3);
    sync();
    @(negedge clk);
    chk("abort busy", int'(busy), 0);
    chk("abort car_x_5", int'(cx[5]), 400);
    chk("abort car_x_0", int'(cx[0]), 0);
    sync();
    vsync = 1'b0;
    repeat (4) sync();

    // 6: async reset mid-UPDATE
    vsync = 1'b1;
    repeat (3) sync();
    reset = 1'b1;
    #1;
    chk("async rst car_x_0", int'(cx[0]), 0);
    chk("async rst car_x_3", int'(cx[3]), 240);
    chk("async rst busy", int'(busy), 0);
    vsync = 1'b0;
    sync();
    reset = 1'b0;
    repeat (2) sync();
`ifdef CAR_PAUSE_EN
    pause = 1'b1;
    repeat (5) frame();
    @(negedge clk);
    chk("paused car_x_0", int'(cx[0]), 0);
    chk("paused car_x_2", int'(cx[2]), 160);
    sync();
    pause = 1'b0;
    frame();
    @(negedge clk);
    chk("unpaused car_x_0", int'(cx[0]), 3);
`else
    repeat (5) frame();
    @(negedge clk);
    chk("5 frames car_x_0", int'(cx[0]), 15);
    chk("5 frames car_x_2", int'(cx[2]), 185);
`endif
    sync();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end, expected completion");
    $fatal(1, "timeout");
  end

endmodule
